// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes,
// late-result skid buffer states and its age counter width.
`default_nettype none

package riscv_wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int AGE_W = 2;
  // Number of pipeline wins a pending late result tolerates before forcing.
  localparam logic [AGE_W-1:0] AGE_FORCE = 2'd2;

  typedef enum logic [1:0] {
    SKID_IDLE  = 2'd0,
    SKID_PEND  = 2'd1,
    SKID_FORCE = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_extract.sv
// Combinational load-data extraction: selects byte/half/word from the
// aligned memory word and sign- or zero-extends it to DATA_WIDTH.
`default_nettype none

module load_extract
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_LW:   o_data = i_word;
      F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// RISC-V writeback stage: registers the MEM/WB result, suppresses x0 writes
// and merges late multicycle results through a one-entry aged skid buffer.
`default_nettype none

module wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  input  logic                     mem_reg_wr,
  input  logic                     mem_mem_to_reg,
  input  logic [2:0]               mem_funct3,
  input  logic [1:0]               mem_addr_lo,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result,
  input  logic [DATA_WIDTH-1:0]    mem_load_data,
  output logic                     mem_stall_req,
  input  logic                     lr_valid,
  output logic                     lr_ready,
  input  logic [ADDRESS_WIDTH-1:0] lr_rd,
  input  logic [DATA_WIDTH-1:0]    lr_data,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data
);

  skid_state_t              r_state;
  logic [AGE_W-1:0]         r_age;
  logic [ADDRESS_WIDTH-1:0] r_skid_rd;
  logic [DATA_WIDTH-1:0]    r_skid_data;
  logic                     r_wrt_en;
  logic [ADDRESS_WIDTH-1:0] r_wrt_dest;
  logic [DATA_WIDTH-1:0]    r_wrt_data;

  logic                     w_force;
  logic                     w_pend;
  logic                     w_pipe;
  logic                     w_accept;
  logic                     w_same_rd;
  logic [AGE_W-1:0]         w_age_next;
  logic [DATA_WIDTH-1:0]    w_load_ext;
  logic [DATA_WIDTH-1:0]    w_pipe_data;

  load_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extract (
    .i_funct3  (mem_funct3),
    .i_addr_lo (mem_addr_lo),
    .i_word    (mem_load_data),
    .o_data    (w_load_ext)
  );

  assign w_force       = (r_state == SKID_FORCE);
  assign w_pend        = (r_state == SKID_PEND);
  assign mem_stall_req = w_force;
  assign lr_ready      = (r_state == SKID_IDLE);

  assign w_pipe      = mem_valid && mem_reg_wr && (mem_rd != '0) && !w_force;
  assign w_pipe_data = mem_mem_to_reg ? w_load_ext : mem_alu_result;
  assign w_accept    = lr_valid && lr_ready && (lr_rd != '0);
  assign w_same_rd   = (mem_rd == r_skid_rd);
  assign w_age_next  = (r_age == '1) ? r_age : r_age + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SKID_IDLE;
      r_age       <= '0;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
      r_wrt_en    <= 1'b0;
      r_wrt_dest  <= '0;
      r_wrt_data  <= '0;
    end else begin
      case (r_state)
        SKID_IDLE: begin
          if (w_accept) begin
            r_state     <= SKID_PEND;
            r_age       <= '0;
            r_skid_rd   <= lr_rd;
            r_skid_data <= lr_data;
          end
        end
        SKID_PEND: begin
          if (w_pipe) begin
            // A younger pipeline write to the same register makes the entry stale.
            if (w_same_rd) begin
              r_state <= SKID_IDLE;
            end else begin
              r_age <= w_age_next;
              if (w_age_next == AGE_FORCE) begin
                r_state <= SKID_FORCE;
              end
            end
          end else begin
            r_state <= SKID_IDLE;
          end
        end
        SKID_FORCE: r_state <= SKID_IDLE;
        default:    r_state <= SKID_IDLE;
      endcase

      if (w_force || (w_pend && !w_pipe)) begin
        r_wrt_en   <= 1'b1;
        r_wrt_dest <= r_skid_rd;
        r_wrt_data <= r_skid_data;
      end else if (w_pipe) begin
        r_wrt_en   <= 1'b1;
        r_wrt_dest <= mem_rd;
        r_wrt_data <= w_pipe_data;
      end else begin
        r_wrt_en   <= 1'b0;
      end
    end
  end

  assign rg_wrt_en   = r_wrt_en;
  assign rg_wrt_dest = r_wrt_dest;
  assign rg_wrt_data = r_wrt_data;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-extract vector table, late-result
// corner sequences and randomized traffic against a behavioural model.
`default_nettype none

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_reg_wr, mem_mem_to_reg;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, mem_load_data;
  logic        mem_stall_req;
  logic        lr_valid, lr_ready;
  logic [4:0]  lr_rd;
  logic [31:0] lr_data;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;

  int checks = 0;
  int errors = 0;

  wb_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg_wr     (mem_reg_wr),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_funct3     (mem_funct3),
    .mem_addr_lo    (mem_addr_lo),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_stall_req  (mem_stall_req),
    .lr_valid       (lr_valid),
    .lr_ready       (lr_ready),
    .lr_rd          (lr_rd),
    .lr_data        (lr_data),
    .rg_wrt_en      (rg_wrt_en),
    .rg_wrt_dest    (rg_wrt_dest),
    .rg_wrt_data    (rg_wrt_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] word;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        exp_en;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[9];

  // Behavioural model state: the pending late result and how often it was bypassed.
  bit          m_pend;
  int          m_bypass;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_en;
  logic [4:0]  m_dest;
  logic [31:0] m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_reg_wr = 0; mem_mem_to_reg = 0; mem_funct3 = 0;
    mem_addr_lo = 0; mem_rd = 0; mem_alu_result = 0; mem_load_data = 0;
    lr_valid = 0; lr_rd = 0; lr_data = 0;
  endtask

  task automatic pipe_alu(input logic [4:0] rd, input logic [31:0] v);
    mem_valid = 1; mem_reg_wr = 1; mem_mem_to_reg = 0; mem_rd = rd; mem_alu_result = v;
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_bypass = 0; m_rd = 0; m_data = 0;
    m_en = 0; m_dest = 0; m_wdata = 0;
  endtask

  // Apply the arbitration rules to the current inputs for one rising edge.
  task automatic model_edge();
    bit          was_pend, forcing, pipe;
    logic [31:0] pdata;
    was_pend = m_pend;
    forcing  = m_pend && (m_bypass == 2);
    pipe     = mem_valid && mem_reg_wr && (mem_rd != 0) && !forcing;
    pdata    = mem_mem_to_reg ? ref_ext(mem_funct3, mem_addr_lo, mem_load_data) : mem_alu_result;
    if (forcing) begin
      m_en = 1; m_dest = m_rd; m_wdata = m_data; m_pend = 0;
    end else if (pipe) begin
      m_en = 1; m_dest = mem_rd; m_wdata = pdata;
      if (m_pend) begin
        if (mem_rd == m_rd) m_pend = 0;
        else m_bypass = m_bypass + 1;
      end
    end else if (m_pend) begin
      m_en = 1; m_dest = m_rd; m_wdata = m_data; m_pend = 0;
    end else begin
      m_en = 0;
    end
    if (!was_pend && lr_valid && lr_rd != 0) begin
      m_pend = 1; m_bypass = 0; m_rd = lr_rd; m_data = lr_data;
    end
  endtask

  initial begin
    vt[0] = '{3'b000, 2'd2, 32'h12F4_5678, 1'b1, 5'd1, 32'h0, 1'b1, 32'hFFFF_FFF4};
    vt[1] = '{3'b100, 2'd2, 32'h12F4_5678, 1'b1, 5'd2, 32'h0, 1'b1, 32'h0000_00F4};
    vt[2] = '{3'b101, 2'd2, 32'h12F4_5678, 1'b1, 5'd3, 32'h0, 1'b1, 32'h0000_12F4};
    vt[3] = '{3'b010, 2'd3, 32'hCAFE_F00D, 1'b1, 5'd4, 32'h0, 1'b1, 32'hCAFE_F00D};
    vt[4] = '{3'b001, 2'd0, 32'h0000_8001, 1'b1, 5'd5, 32'h0, 1'b1, 32'hFFFF_8001};
    vt[5] = '{3'b000, 2'd3, 32'h8000_0000, 1'b1, 5'd6, 32'h0, 1'b1, 32'hFFFF_FF80};
    vt[6] = '{3'b101, 2'd0, 32'hFFFF_8001, 1'b1, 5'd7, 32'h0, 1'b1, 32'h0000_8001};
    vt[7] = '{3'b011, 2'd1, 32'hA5A5_1234, 1'b1, 5'd8, 32'h0, 1'b1, 32'hA5A5_1234};
    vt[8] = '{3'b000, 2'd0, 32'h0,         1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'hA5A5_1234};

    idle_inputs();
    rst = 1;
    step();
    step();
    chk("reset_en", 32'(rg_wrt_en), 32'd0);
    chk("reset_dest", 32'(rg_wrt_dest), 32'd0);
    chk("reset_data", rg_wrt_data, 32'd0);
    chk("reset_stall", 32'(mem_stall_req), 32'd0);
    chk("reset_lr_ready", 32'(lr_ready), 32'd1);
    rst = 0;
    step();

    for (int i = 0; i < 9; i++) begin
      mem_valid = 1; mem_reg_wr = 1;
      mem_funct3 = vt[i].f3; mem_addr_lo = vt[i].lo; mem_load_data = vt[i].word;
      mem_mem_to_reg = vt[i].m2r; mem_rd = vt[i].rd; mem_alu_result = vt[i].alu;
      step();
      chk($sformatf("vec%0d_en", i), 32'(rg_wrt_en), 32'(vt[i].exp_en));
      chk($sformatf("vec%0d_data", i), rg_wrt_data, vt[i].exp_data);
      if (vt[i].exp_en) chk($sformatf("vec%0d_dest", i), 32'(rg_wrt_dest), 32'(vt[i].rd));
    end
    idle_inputs();
    step();

    // Late result into an idle pipeline.
    lr_valid = 1; lr_rd = 5'd7; lr_data = 32'h55;
    step();
    lr_valid = 0;
    chk("lr_idle_ready_low", 32'(lr_ready), 32'd0);
    chk("lr_idle_no_write_yet", 32'(rg_wrt_en), 32'd0);
    step();
    chk("lr_idle_en", 32'(rg_wrt_en), 32'd1);
    chk("lr_idle_dest", 32'(rg_wrt_dest), 32'd7);
    chk("lr_idle_data", rg_wrt_data, 32'h55);
    chk("lr_idle_ready_high", 32'(lr_ready), 32'd1);

    // Two pipeline wins then a forced drain.
    lr_valid = 1; lr_rd = 5'd7; lr_data = 32'h77;
    step();
    lr_valid = 0;
    pipe_alu(5'd3, 32'h303);
    step();
    chk("force_w3_dest", 32'(rg_wrt_dest), 32'd3);
    chk("force_w3_stall", 32'(mem_stall_req), 32'd0);
    pipe_alu(5'd4, 32'h404);
    step();
    chk("force_w4_dest", 32'(rg_wrt_dest), 32'd4);
    chk("force_stall_high", 32'(mem_stall_req), 32'd1);
    pipe_alu(5'd5, 32'h505);
    step();
    chk("force_w7_en", 32'(rg_wrt_en), 32'd1);
    chk("force_w7_dest", 32'(rg_wrt_dest), 32'd7);
    chk("force_w7_data", rg_wrt_data, 32'h77);
    chk("force_stall_low", 32'(mem_stall_req), 32'd0);
    step();
    chk("force_w5_dest", 32'(rg_wrt_dest), 32'd5);
    chk("force_w5_data", rg_wrt_data, 32'h505);
    idle_inputs();
    step();

    // Same-register conflict: pipeline write supersedes the pending entry.
    lr_valid = 1; lr_rd = 5'd9; lr_data = 32'hAA;
    step();
    lr_valid = 0;
    pipe_alu(5'd9, 32'h1);
    step();
    chk("conflict_dest", 32'(rg_wrt_dest), 32'd9);
    chk("conflict_data", rg_wrt_data, 32'h1);
    chk("conflict_lr_ready", 32'(lr_ready), 32'd1);
    idle_inputs();
    step();
    chk("conflict_no_stale", 32'(rg_wrt_en), 32'd0);

    // Asynchronous reset while an entry is pending and a write is in flight.
    lr_valid = 1; lr_rd = 5'd12; lr_data = 32'hC0C0;
    step();
    lr_valid = 0;
    pipe_alu(5'd3, 32'h33);
    step();
    chk("rst_pre_en", 32'(rg_wrt_en), 32'd1);
    idle_inputs();
    rst = 1;
    #1;
    chk("rst_async_en", 32'(rg_wrt_en), 32'd0);
    chk("rst_async_ready", 32'(lr_ready), 32'd1);
    step();
    rst = 0;
    step();
    chk("rst_no_drain_1", 32'(rg_wrt_en), 32'd0);
    step();
    chk("rst_no_drain_2", 32'(rg_wrt_en), 32'd0);

    // Randomized traffic against the behavioural model.
    rst = 1;
    step();
    rst = 0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      mem_valid      = ($urandom % 4) != 0;
      mem_reg_wr     = ($urandom % 5) != 0;
      mem_mem_to_reg = $urandom % 2;
      mem_funct3     = 3'($urandom % 8);
      mem_addr_lo    = 2'($urandom % 4);
      mem_rd         = 5'($urandom % 8);
      mem_alu_result = $urandom;
      mem_load_data  = $urandom;
      lr_valid       = ($urandom % 3) == 0;
      lr_rd          = 5'($urandom % 8);
      lr_data        = $urandom;
      model_edge();
      step();
      chk("rand_en", 32'(rg_wrt_en), 32'(m_en));
      chk("rand_dest", 32'(rg_wrt_dest), 32'(m_dest));
      chk("rand_data", rg_wrt_data, m_wdata);
      chk("rand_stall", 32'(mem_stall_req), 32'(m_pend && m_bypass == 2));
      chk("rand_lr_ready", 32'(lr_ready), 32'(!m_pend));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V pipeline, directly upstream of the register file write port. Registers the MEM/WB result, extracts and sign/zero-extends load data, suppresses x0 writes, and merges late results from the multicycle unit through a one-entry skid buffer with bounded wait. Its registered write outputs drive the register file, which samples them on the following falling edge.

## Interface
- DATA_WIDTH, 32, register/data width
- ADDRESS_WIDTH, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_reg_wr  in  1  instruction writes rd
- mem_mem_to_reg  in  1  1 = load data, 0 = ALU result
- mem_funct3  in  3  load type
- mem_addr_lo  in  2  low bits of load address
- mem_rd  in  ADDRESS_WIDTH  destination register
- mem_alu_result  in  DATA_WIDTH  ALU result
- mem_load_data  in  DATA_WIDTH  raw aligned memory word
- mem_stall_req  out  1  upstream must hold MEM inputs this cycle
- lr_valid  in  1  late result offered
- lr_ready  out  1  late result accepted when lr_valid && lr_ready
- lr_rd  in  ADDRESS_WIDTH  late result destination
- lr_data  in  DATA_WIDTH  late result value
- rg_wrt_en  out  1  register file write enable (registered)
- rg_wrt_dest  out  ADDRESS_WIDTH  write address (registered)
- rg_wrt_data  out  DATA_WIDTH  write data (registered)

## Operation
- Load extract (funct3): 000 LB sign-ext byte[addr_lo]; 001 LH sign-ext half[addr_lo[1]]; 010 LW full word, addr_lo ignored; 100 LBU; 101 LHU zero-ext; other codes = full word.
- Pipeline write candidate: mem_valid && mem_reg_wr && mem_rd != 0 && !mem_stall_req. Writes with rd = 0 never assert rg_wrt_en.
- Skid: one entry {rd, data}, 2-bit saturating age. lr_ready = skid empty. Accepted lr with lr_rd = 0 is dropped (entry stays empty).
- Skid FSM: IDLE (empty) -> PEND on accept, age=0. PEND: if pipeline candidate present, age+1; reaching age 2 -> FORCE; otherwise skid drains -> IDLE. FORCE: mem_stall_req=1, skid drains -> IDLE.
- Per-cycle write select, priority order: FORCE skid; pipeline candidate; PEND skid; none (rg_wrt_en=0, dest/data hold previous value).
- Same-rd conflict: pipeline candidate rd equals pending skid rd -> pipeline write wins, skid entry discarded (-> IDLE), because the pipeline instruction is younger.
- Skid cannot accept and drain in the same cycle; lr_ready deasserts the cycle after acceptance.

## Timing
- Reset values: rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0, mem_stall_req=0, lr_ready=1, skid IDLE, age 0.
- Pipeline path latency: MEM inputs at rising edge N -> rg_* valid after edge N, written by register file at the falling edge of cycle N.
- Late path latency: accept at edge N -> earliest rg_* at edge N+1; worst case edge N+3 (two pipeline wins, then FORCE).
- mem_stall_req is a pure decode of FSM state, high for exactly one cycle per FORCE.
- Reset mid-operation: pending skid entry lost, in-flight write cancelled immediately (rg_wrt_en falls asynchronously).

## Structure
- Shared package riscv_wb_pkg: load funct3 constants (LB/LH/LW/LBU/LHU), skid state enum {IDLE, PEND, FORCE}, age width constant.
- Sub-module load_extract: combinational funct3/addr_lo/word -> extended data; instanced once.
- Top holds skid FSM, write-select mux, and output registers.

## Test plan
- Reset then LB, addr_lo=2, word 0x12F45678 -> rg_wrt_data=0xFFFFFFF4; LBU same -> 0x000000F4; LHU addr_lo=2 -> 0x000012F4.
- ALU write rd=0, result 0xDEADBEEF -> rg_wrt_en stays 0 that cycle.
- lr_valid rd=7 data=0x55 with idle pipeline -> lr_ready low next cycle, rg_wrt_en=1, dest=7, data=0x55 one edge after accept, lr_ready high again.
- Late rd=7 accepted while pipeline writes rd=3,4,5 back-to-back -> rd=3, rd=4 written, then mem_stall_req=1 for one cycle and rd=7 written; rd=5 written the cycle after.
- Late rd=9 pending, pipeline writes rd=9 value 0x1 -> only 0x1 written to x9, skid IDLE, lr_ready=1.
- rst asserted while skid PEND and rg_wrt_en=1 -> rg_wrt_en=0 immediately, lr_ready=1, no write of pending entry after release.
